// File: rtl/pong_game_ctrl.sv
// Game-flow sequencer for the pong datapath.
// It decides when the ball is served and released, scores misses, and declares the winner.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       score_reset,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       ball_run,
  output logic       serve_l,
  output logic       serve_r,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_e;

  localparam logic [2:0] WIN_VAL    = 3'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

  state_e     state_q, state_d;
  logic       start_q, pause_q;
  logic [7:0] cnt_q, cnt_d;
  logic       srv_q, srv_d;
  logic [2:0] score_l_q, score_l_d;
  logic [2:0] score_r_q, score_r_d;
  logic [1:0] winner_q, winner_d;
  logic       ball_run_q, ball_run_d;
  logic       serve_l_q, serve_l_d;
  logic       serve_r_q, serve_r_d;

  logic start_e, pause_e;
  logic serve_done, point_done, game_won, entering_serve;

  assign start_e    = start & ~start_q;
  assign pause_e    = pause & ~pause_q;
  assign serve_done = frame_tick && (cnt_q == SERVE_LAST);
  assign point_done = frame_tick && (cnt_q == POINT_LAST);
  assign game_won   = (score_l_q == WIN_VAL) || (score_r_q == WIN_VAL);

  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    return (s >= WIN_VAL) ? s : s + 3'd1;
  endfunction

  // Edge-detect copies reset high so a button held through reset does not fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (score_reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (start_e) state_d = SERVE;
        SERVE: if (serve_done) state_d = PLAY;
        PLAY: begin
          if (miss_l || miss_r) state_d = POINT;
          else if (pause_e)     state_d = PAUSE;
        end
        PAUSE: if (pause_e) state_d = PLAY;
        POINT: if (point_done) state_d = game_won ? OVER : SERVE;
        OVER:  if (start_e) state_d = SERVE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    srv_d     = srv_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;

    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (frame_tick && (state_q == SERVE || state_q == POINT)) begin
      cnt_d = cnt_q + 8'd1;
    end

    if (score_reset) begin
      score_l_d = 3'd0;
      score_r_d = 3'd0;
      winner_d  = 2'b00;
      srv_d     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_e) begin
            score_l_d = 3'd0;
            score_r_d = 3'd0;
            winner_d  = 2'b00;
            srv_d     = 1'b1;
          end
        end
        PLAY: begin
          if (miss_l) begin
            score_r_d = sat_inc(score_r_q);
            srv_d     = 1'b1;
          end else if (miss_r) begin
            score_l_d = sat_inc(score_l_q);
            srv_d     = 1'b0;
          end
        end
        POINT: begin
          if (point_done && game_won) begin
            winner_d = (score_l_q == WIN_VAL) ? 2'b01 : 2'b10;
          end
        end
        OVER: begin
          // The loser of the finished game serves first.
          if (start_e) begin
            score_l_d = 3'd0;
            score_r_d = 3'd0;
            winner_d  = 2'b00;
            srv_d     = (winner_q == 2'b01);
          end
        end
        default: ;
      endcase
    end

    entering_serve = (state_d == SERVE) && (state_q != SERVE);
    ball_run_d     = (state_d == PLAY);
    serve_l_d      = entering_serve && !srv_d;
    serve_r_d      = entering_serve && srv_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b1;
      pause_q    <= 1'b1;
      cnt_q      <= 8'd0;
      srv_q      <= 1'b1;
      score_l_q  <= 3'd0;
      score_r_q  <= 3'd0;
      winner_q   <= 2'b00;
      ball_run_q <= 1'b0;
      serve_l_q  <= 1'b0;
      serve_r_q  <= 1'b0;
    end else begin
      start_q    <= start;
      pause_q    <= pause;
      cnt_q      <= cnt_d;
      srv_q      <= srv_d;
      score_l_q  <= score_l_d;
      score_r_q  <= score_r_d;
      winner_q   <= winner_d;
      ball_run_q <= ball_run_d;
      serve_l_q  <= serve_l_d;
      serve_r_q  <= serve_r_d;
    end
  end

  assign ball_run = ball_run_q;
  assign serve_l  = serve_l_q;
  assign serve_r  = serve_r_q;
  assign score_l  = score_l_q;
  assign score_r  = score_r_q;
  assign winner   = winner_q;
  assign state    = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl.
// A game-rule reference model queues the expected outputs for each clock, and a monitor compares them.
module tb_pong_game_ctrl;

  localparam int WIN = 3;
  localparam int SF  = 5;
  localparam int PF  = 3;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, start, pause, score_reset, miss_l, miss_r;
  logic       ball_run, serve_l, serve_r;
  logic [2:0] score_l, score_r, state;
  logic [1:0] winner;

  pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .pause(pause),
    .score_reset(score_reset), .miss_l(miss_l), .miss_r(miss_r), .ball_run(ball_run),
    .serve_l(serve_l), .serve_r(serve_r), .score_l(score_l), .score_r(score_r),
    .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       run;
    logic       pl;
    logic       pr;
    logic [2:0] sl;
    logic [2:0] sr;
    logic [1:0] win;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: game mode by number, frames counted since entering the mode.
  int m_mode, m_frames, m_left, m_right, m_win, m_server;
  bit m_prev_start, m_prev_pause, m_run, m_pulse_l, m_pulse_r;

  task automatic model_reset();
    m_mode = 0; m_frames = 0; m_left = 0; m_right = 0; m_win = 0; m_server = 1;
    m_prev_start = 1; m_prev_pause = 1; m_run = 0; m_pulse_l = 0; m_pulse_r = 0;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit clr, input bit tk,
                            input bit ml, input bit mr);
    bit rise_s, rise_p;
    int next;
    rise_s = st && !m_prev_start;
    rise_p = pa && !m_prev_pause;
    m_prev_start = st;
    m_prev_pause = pa;
    next = m_mode;
    if (clr) begin
      next = 0; m_left = 0; m_right = 0; m_win = 0; m_server = 1;
    end else begin
      case (m_mode)
        0: if (rise_s) begin
          next = 1; m_left = 0; m_right = 0; m_win = 0; m_server = 1;
        end
        1: if (tk) begin
          m_frames++;
          if (m_frames == SF) next = 2;
        end
        2: begin
          if (ml) begin
            m_right = (m_right + 1 > WIN) ? WIN : m_right + 1; m_server = 1; next = 4;
          end else if (mr) begin
            m_left = (m_left + 1 > WIN) ? WIN : m_left + 1; m_server = 0; next = 4;
          end else if (rise_p) next = 3;
        end
        3: if (rise_p) next = 2;
        4: if (tk) begin
          m_frames++;
          if (m_frames == PF) begin
            if (m_left == WIN)       begin next = 5; m_win = 1; end
            else if (m_right == WIN) begin next = 5; m_win = 2; end
            else next = 1;
          end
        end
        5: if (rise_s) begin
          m_server = (m_win == 1) ? 1 : 0;
          next = 1; m_left = 0; m_right = 0; m_win = 0;
        end
        default: next = 0;
      endcase
    end
    m_pulse_l = (next == 1 && m_mode != 1 && m_server == 0);
    m_pulse_r = (next == 1 && m_mode != 1 && m_server == 1);
    if (next != m_mode) m_frames = 0;
    m_mode = next;
    m_run  = (m_mode == 2);
  endtask

  task automatic apply_stimulus(input bit st, input bit pa, input bit clr, input bit tk,
                                input bit ml, input bit mr, input bit rn);
    exp_t e;
    @(negedge clk);
    rst_n = rn; start = st; pause = pa; score_reset = clr;
    frame_tick = tk; miss_l = ml; miss_r = mr;
    if (!rn) model_reset();
    else     model_step(st, pa, clr, tk, ml, mr);
    e.st = 3'(m_mode); e.run = m_run; e.pl = m_pulse_l; e.pr = m_pulse_r;
    e.sl = 3'(m_left); e.sr = 3'(m_right); e.win = 2'(m_win);
    exp_q.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    exp_t act;
    act = '{st: state, run: ball_run, pl: serve_l, pr: serve_r, sl: score_l, sr: score_r, win: winner};
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("[TB] FAIL outputs @%0t: got st=%0d run=%0b pl=%0b pr=%0b score=%0d:%0d win=%b, want st=%0d run=%0b pl=%0b pr=%0b score=%0d:%0d win=%b",
               $time, act.st, act.run, act.pl, act.pr, act.sl, act.sr, act.win,
               e.st, e.run, e.pl, e.pr, e.sl, e.sr, e.win);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin : driver
    bit ml, mr;
    rst_n = 1'b0; start = 1'b1; pause = 1'b0; score_reset = 1'b0;
    frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    model_reset();

    // Start held across reset release must not fire.
    repeat (3) apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (4) apply_stimulus(1, 0, 0, 0, 0, 0, 1);
    repeat (2) apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    repeat (2) apply_stimulus(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2 * SF + 2; i++) apply_stimulus(0, 0, 0, i[0], 0, 0, 1);
    repeat (6) apply_stimulus(0, 1, 0, 0, 0, 0, 1);
    repeat (2) apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1, 1);
    apply_stimulus(0, 1, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < PF + 3; i++) apply_stimulus(0, 0, 0, 1, 0, 0, 1);
    apply_stimulus(0, 0, 1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);

    for (int c = 0; c < 15000; c++) begin
      if ($urandom_range(1999) == 0) begin
        repeat (2) apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      end
      ml = ($urandom_range(15) == 0);
      mr = ($urandom_range(15) == 0);
      apply_stimulus(($urandom_range(5) == 0), ($urandom_range(9) == 0),
                     ($urandom_range(499) == 0), ($urandom_range(2) == 0), ml, mr, 1'b1);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-flow sequencer for the VGA pong datapath. Sits between the debounced player buttons, the frame timing generator and the ball/paddle engine. Its state machine decides when the ball moves, when and from which side it is served, when points are scored and when a game is won. It owns both 3-bit scores and the winner flag consumed by the score renderer.

## Interface

Parameters:
- `WIN_SCORE`, default 7: points that end a game; legal range 1..7.
- `SERVE_FRAMES`, default 60: frames the ball is held on the server's paddle before release; legal range 1..255.
- `POINT_FRAMES`, default 30: frames the field freezes after a miss; legal range 1..255.

Ports:
- `clk` in 1: pixel clock, 25.175 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_tick` in 1: one-cycle strobe, once per frame, from the timing generator at start of vertical sync.
- `start` in 1: debounced start button, level.
- `pause` in 1: debounced pause button, level.
- `score_reset` in 1: level, synchronous abort/clear.
- `miss_l` in 1: one-cycle strobe from the ball engine when the ball passes the left paddle. Right player scores.
- `miss_r` in 1: one-cycle strobe from the ball engine when the ball passes the right paddle. Left player scores.
- `ball_run` out 1: ball engine advances position only while high.
- `serve_l` out 1: one-cycle strobe telling the ball engine to place the ball at the left paddle.
- `serve_r` out 1: one-cycle strobe telling the ball engine to place the ball at the right paddle.
- `score_l` out 3: left score.
- `score_r` out 3: right score.
- `winner` out 2: 00 none, 01 left, 10 right.
- `state` out 3: current state encoding, for debug and display.

## Operation

- States and encodings: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5. Encodings 6 and 7 are unreachable and recover to IDLE on the next clock.
- Edge detect: `start_e` = `start` & ~`start_q`; `pause_e` likewise. `start_q` and `pause_q` reset to 1, so a button held through reset release does not fire.
- Dwell counter: 8 bits, cleared on every state change, incremented on `frame_tick` while in SERVE or POINT.
  - The exit condition is `frame_tick` with counter == N-1, which gives exactly N frame ticks of dwell.
- Serve side register `srv`: 0 = left, 1 = right; resets to 1.
- IDLE:
  - `ball_run`=0.
  - `start_e` → SERVE. Clears both scores and `winner`; `srv`=1.
- SERVE:
  - Entry cycle pulses `serve_l` if `srv`=0, otherwise `serve_r`. The pulse is issued on the cycle the state register first reads SERVE.
  - `ball_run`=0.
  - After `SERVE_FRAMES` ticks → PLAY.
- PLAY:
  - `ball_run`=1.
  - `miss_l` → POINT, `score_r`+1, `srv`=1.
  - Else `miss_r` → POINT, `score_l`+1, `srv`=0.
  - If both miss strobes arrive in the same cycle, `miss_l` wins; only one point is awarded.
  - Else `pause_e` → PAUSE.
- PAUSE:
  - `ball_run`=0.
  - Miss strobes are ignored.
  - `pause_e` → PLAY.
  - The dwell counter is not used.
- POINT:
  - `ball_run`=0.
  - After `POINT_FRAMES` ticks: if either score == `WIN_SCORE`, go to OVER and set `winner` to that side; otherwise go to SERVE.
- OVER:
  - `ball_run`=0; scores and `winner` hold.
  - `start_e` → SERVE. Clears scores and `winner`; `srv` = the loser of the finished game.
- Miss strobes outside PLAY are ignored in every state.
- Score arithmetic is 3-bit and saturates at `WIN_SCORE`; it never wraps.
- `score_reset`=1 has priority over all other events in every state:
  - next state IDLE;
  - scores 0, `winner` 00, `srv`=1;
  - no serve pulse.

## Timing

- All outputs are registered; no combinational path from any input to any output.
- Reset values: `state`=IDLE, `ball_run`=0, `serve_l`=0, `serve_r`=0, `score_l`=0, `score_r`=0, `winner`=00, dwell counter 0, `srv`=1.
- Input edge to state change: `start_e`/`pause_e` are computed from the registered `_q` copy, so the state changes on the clock after `start`/`pause` rises.
- `ball_run` changes on the same clock edge as `state`.
- Miss to score: a miss strobe at cycle t gives updated score and `state`=POINT at t+1, with `ball_run` low from t+1.
- A `frame_tick` that coincides with a state change is not counted for the new state.
- Reset assertion mid-game clears everything asynchronously. Release is synchronised by the system; the first edge after release evaluates from IDLE.

## Test plan

- Reset, then `start` rise → IDLE→SERVE. `serve_r` pulses exactly one cycle. `ball_run` stays 0 for 60 `frame_tick`s, then rises with `state`=2.
- In PLAY, pulse `miss_r` → `score_l`=1, `state`=4. After 30 ticks: `state`=1 and `serve_l` pulses once.
- `miss_l` and `miss_r` in the same cycle → only `score_r` increments, `srv`=right. A miss pulsed during PAUSE changes nothing.
- With `WIN_SCORE`=3, award right 3 points → after the third POINT dwell: `state`=5, `winner`=10, `score_r`=3. `start` → scores 0, `serve_l` pulse.
- `pause` rise in PLAY → `state`=3, `ball_run`=0. Second rise → PLAY. `pause` held high continuously causes no toggling.
- Drive `score_reset` mid-SERVE, and separately assert `rst_n` low mid-POINT → IDLE, all outputs at reset values, no serve pulse. `start` held across reset release → stays IDLE.
